// File: rtl/uart_tx_simple_if.sv
// Byte-in / serial-out handshake bundle for uart_tx_simple.
// master drives bytes in; slave is the transmitter itself.
interface uart_tx_simple_if;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       serial_tx;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_byte,
        output tx_valid,
        input  tx_ready,
        input  serial_tx,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_byte,
        input  tx_valid,
        output tx_ready,
        output serial_tx,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_simple.sv
// UART transmitter: one byte per valid/ready handshake, sent LSB-first as
// start, 8 data bits, optional parity, then 1 or 2 stop bits.
module uart_tx_simple #(
    parameter int CLK_FREQ_HZ = 33330000,
    parameter int BAUD_RATE   = 115200,
    parameter int PARITY      = 0,
    parameter int STOP        = 1
) (
    input logic            clk,
    input logic            rst,
    uart_tx_simple_if.slave tx
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [2:0]       LAST_STOP_IDX = 3'(STOP - 1);
    localparam bit               HAS_PARITY = (PARITY != 0);
    localparam bit               ODD_PARITY = (PARITY == 1);

    generate
        if (PARITY < 0 || PARITY > 2 || (STOP != 1 && STOP != 2) || CLKS_PER_BIT < 2) begin : g_bad_params
            $error("uart_tx_simple: illegal parameters PARITY=%0d STOP=%0d CLKS_PER_BIT=%0d",
                   PARITY, STOP, CLKS_PER_BIT);
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] baud_cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic             parity_reg;
    logic             serial_tx_reg;
    logic             tx_ready_reg;
    logic             tx_busy_reg;
    logic             tx_done_reg;

    logic bit_end;
    logic last_stop;

    assign bit_end   = (baud_cnt_reg == CNT_LAST);
    assign last_stop = (bit_idx_reg == LAST_STOP_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            baud_cnt_reg  <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            parity_reg    <= 1'b0;
            serial_tx_reg <= 1'b1;
            tx_ready_reg  <= 1'b1;
            tx_busy_reg   <= 1'b0;
            tx_done_reg   <= 1'b0;
        end else begin
            tx_done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    baud_cnt_reg <= '0;
                    bit_idx_reg  <= '0;
                    if (tx.tx_valid) begin
                        // Parity is fixed at latch time so later tx_byte changes cannot leak in.
                        shift_reg     <= tx.tx_byte;
                        parity_reg    <= ODD_PARITY ? ~^tx.tx_byte : ^tx.tx_byte;
                        serial_tx_reg <= 1'b0;
                        tx_ready_reg  <= 1'b0;
                        tx_busy_reg   <= 1'b1;
                        state_reg     <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt_reg  <= '0;
                        serial_tx_reg <= shift_reg[0];
                        shift_reg     <= {1'b0, shift_reg[7:1]};
                        bit_idx_reg   <= '0;
                        state_reg     <= S_DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            bit_idx_reg <= '0;
                            if (HAS_PARITY) begin
                                serial_tx_reg <= parity_reg;
                                state_reg     <= S_PARITY;
                            end else begin
                                serial_tx_reg <= 1'b1;
                                state_reg     <= S_STOP;
                            end
                        end else begin
                            serial_tx_reg <= shift_reg[0];
                            shift_reg     <= {1'b0, shift_reg[7:1]};
                            bit_idx_reg   <= bit_idx_reg + 1'b1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        baud_cnt_reg  <= '0;
                        bit_idx_reg   <= '0;
                        serial_tx_reg <= 1'b1;
                        state_reg     <= S_STOP;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        if (last_stop) begin
                            bit_idx_reg  <= '0;
                            tx_ready_reg <= 1'b1;
                            tx_busy_reg  <= 1'b0;
                            state_reg    <= S_IDLE;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                        // Registered pulse lands on the final cycle of the last stop bit.
                        if (last_stop && baud_cnt_reg == CNT_PRE) begin
                            tx_done_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg     <= S_IDLE;
                    serial_tx_reg <= 1'b1;
                    tx_ready_reg  <= 1'b1;
                    tx_busy_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign tx.serial_tx = serial_tx_reg;
    assign tx.tx_ready  = tx_ready_reg;
    assign tx.tx_busy   = tx_busy_reg;
    assign tx.tx_done   = tx_done_reg;

endmodule

// File: tb/tb_uart_tx_simple.sv
// Directed bench for uart_tx_simple: four parameter sets share one stimulus
// stream, selected by sel; every frame is checked cycle by cycle.
module tb_uart_tx_simple;
    localparam int CPB = 289;

    logic       clk_tb = 1'b0;
    logic       rst;
    logic [7:0] drv_byte;
    logic       drv_valid;
    int         sel;

    always #5 clk_tb = ~clk_tb;

    uart_tx_simple_if if_def ();
    uart_tx_simple_if if_even ();
    uart_tx_simple_if if_odd ();
    uart_tx_simple_if if_stop2 ();

    assign if_def.tx_byte    = drv_byte;
    assign if_even.tx_byte   = drv_byte;
    assign if_odd.tx_byte    = drv_byte;
    assign if_stop2.tx_byte  = drv_byte;
    assign if_def.tx_valid   = drv_valid && (sel == 0);
    assign if_even.tx_valid  = drv_valid && (sel == 1);
    assign if_odd.tx_valid   = drv_valid && (sel == 2);
    assign if_stop2.tx_valid = drv_valid && (sel == 3);

    uart_tx_simple #(.PARITY(0), .STOP(1)) u_def   (.clk(clk_tb), .rst(rst), .tx(if_def));
    uart_tx_simple #(.PARITY(2), .STOP(1)) u_even  (.clk(clk_tb), .rst(rst), .tx(if_even));
    uart_tx_simple #(.PARITY(1), .STOP(1)) u_odd   (.clk(clk_tb), .rst(rst), .tx(if_odd));
    uart_tx_simple #(.PARITY(0), .STOP(2)) u_stop2 (.clk(clk_tb), .rst(rst), .tx(if_stop2));

    logic obs_tx, obs_ready, obs_busy, obs_done;
    always_comb begin
        obs_tx = if_def.serial_tx; obs_ready = if_def.tx_ready;
        obs_busy = if_def.tx_busy; obs_done = if_def.tx_done;
        case (sel)
            1: begin obs_tx = if_even.serial_tx; obs_ready = if_even.tx_ready;
                     obs_busy = if_even.tx_busy; obs_done = if_even.tx_done; end
            2: begin obs_tx = if_odd.serial_tx; obs_ready = if_odd.tx_ready;
                     obs_busy = if_odd.tx_busy; obs_done = if_odd.tx_done; end
            3: begin obs_tx = if_stop2.serial_tx; obs_ready = if_stop2.tx_ready;
                     obs_busy = if_stop2.tx_busy; obs_done = if_stop2.tx_done; end
            default: ;
        endcase
    end

    int cyc = 0;
    always @(posedge clk_tb) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int hi_run = 0;
    int gap_run = 0;
    int start_cyc = 0;
    int prev_start = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
            $error("check %s did not match", tag);
        end
    endtask

    task automatic track();
        if (obs_tx) hi_run++;
        else hi_run = 0;
    endtask

    // Returns at the falling edge just after the handshake edge (frame cycle 0).
    task automatic handshake(input logic [7:0] b, input logic hold);
        @(negedge clk_tb);
        drv_byte  = b;
        drv_valid = 1'b1;
        @(negedge clk_tb);
        if (!hold) drv_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " idle tx"},    32'(obs_tx),    32'd1);
        check({tag, " idle ready"}, 32'(obs_ready), 32'd1);
        check({tag, " idle busy"},  32'(obs_busy),  32'd0);
        check({tag, " idle done"},  32'(obs_done),  32'd0);
    endtask

    // Walks a whole frame from cycle 0; optionally pulses tx_valid at inj_c.
    task automatic walk(input string tag, input logic [7:0] b, input int has_par,
                        input logic par_bit, input int nstop, input int inj_c,
                        input logic [7:0] inj_b);
        logic [11:0] bits;
        int          nbits;
        int          total;
        logic [7:0]  got_b;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
        nbits = 9;
        if (has_par != 0) begin bits[9] = par_bit; nbits = 10; end
        for (int s = 0; s < nstop; s++) begin bits[nbits] = 1'b1; nbits++; end
        total = nbits * CPB;
        gap_run = hi_run;
        prev_start = start_cyc;
        start_cyc = cyc;
        got_b = 8'h00;
        for (int c = 0; c < total; c++) begin
            if (c != 0) @(negedge clk_tb);
            if (inj_c >= 0 && c == inj_c) begin drv_byte = inj_b; drv_valid = 1'b1; end
            if (inj_c >= 0 && c == inj_c + 1) drv_valid = 1'b0;
            check({tag, " tx"},    32'(obs_tx),    32'(bits[c / CPB]));
            check({tag, " done"},  32'(obs_done),  32'(c == total - 1));
            check({tag, " ready"}, 32'(obs_ready), 32'd0);
            check({tag, " busy"},  32'(obs_busy),  32'd1);
            if (c / CPB >= 1 && c / CPB <= 8 && c % CPB == CPB / 2) got_b[c / CPB - 1] = obs_tx;
            track();
        end
        @(negedge clk_tb);
        check_idle(tag);
        track();
        check({tag, " decoded"}, 32'(got_b), 32'(b));
        $display("frame %s byte 0x%02h: %0d cycles, decoded 0x%02h", tag, b, total, got_b);
    endtask

    initial begin
        rst = 1'b1; drv_byte = 8'h00; drv_valid = 1'b0; sel = 0;
        repeat (3) @(negedge clk_tb);
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            check_idle("reset");
        end
        sel = 0;
        @(negedge clk_tb);
        rst = 1'b0;
        @(negedge clk_tb);
        check_idle("post-reset");

        // T1 + T2: default framing, several patterns
        handshake(8'h88, 1'b0); walk("t1 0x88", 8'h88, 0, 1'b0, 1, -10, 8'h00);
        handshake(8'h00, 1'b0); walk("t2 0x00", 8'h00, 0, 1'b0, 1, -10, 8'h00);
        handshake(8'hFF, 1'b0); walk("t2 0xFF", 8'hFF, 0, 1'b0, 1, -10, 8'h00);
        handshake(8'hA5, 1'b0); walk("t2 0xA5", 8'hA5, 0, 1'b0, 1, -10, 8'h00);

        // T3: parity bits, hand-computed
        sel = 1;
        handshake(8'h07, 1'b0); walk("t3 even 0x07", 8'h07, 1, 1'b1, 1, -10, 8'h00);
        sel = 2;
        handshake(8'h00, 1'b0); walk("t3 odd 0x00", 8'h00, 1, 1'b1, 1, -10, 8'h00);
        handshake(8'h01, 1'b0); walk("t3 odd 0x01", 8'h01, 1, 1'b0, 1, -10, 8'h00);

        // T4: two stop bits, tx_valid held high across both frames
        sel = 3;
        handshake(8'h55, 1'b1);
        drv_byte = 8'hA3;
        walk("t4 0x55", 8'h55, 0, 1'b0, 2, -10, 8'h00);
        @(negedge clk_tb);
        drv_valid = 1'b0;
        walk("t4 0xA3", 8'hA3, 0, 1'b0, 2, -10, 8'h00);
        check("t4 start spacing", 32'(start_cyc - prev_start), 32'd3180);
        check("t4 high gap>=578", 32'(gap_run >= 578), 32'd1);

        // T5: mid-frame valid pulse is dropped
        sel = 0;
        handshake(8'h81, 1'b0); walk("t5 0x81", 8'h81, 0, 1'b0, 1, 1000, 8'h3C);
        repeat (10) @(negedge clk_tb);
        check_idle("t5 no queued frame");

        // T6: reset during data bit 4
        handshake(8'h00, 1'b0);
        repeat (5 * CPB + 100) @(negedge clk_tb);
        check("t6 bit4 low", 32'(obs_tx), 32'd0);
        check("t6 busy before rst", 32'(obs_busy), 32'd1);
        rst = 1'b1;
        #1;
        check_idle("t6 async rst");
        @(negedge clk_tb);
        rst = 1'b0;
        @(negedge clk_tb);
        check_idle("t6 after release");
        handshake(8'h5A, 1'b0); walk("t6 0x5A", 8'h5A, 0, 1'b0, 1, -10, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
